// File: rtl/ila_capture_controller.sv
// ila_capture_controller: circular-buffer logic analyser capture with pre/post trigger window
// Ports: clock/reset (async, active-high); arm starts a capture, trigger marks the trigger sample,
// sample_data is stored every ARMED/POST cycle, post_count sets samples kept after the trigger.
// rd_en/rd_addr read the frozen capture chronologically (one-cycle latency, rd_data/rd_valid).
// Status: armed/capturing/done one-hot state flags, trig_pos, valid_count.
module ila_capture_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  armed,
  output logic                  capturing,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_pos,
  output logic [ADDR_WIDTH:0]   valid_count,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);
  localparam logic [ADDR_WIDTH:0] depth = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, post_lat, left, rd_phys;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic                  start, wr, last;
  // post_count is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and latches as-is
  assign start   = (state == IDLE || state == DONE) && arm;
  assign wr      = state == ARMED || state == POST;
  assign last    = (state == ARMED && trigger && post_lat == '0) || (state == POST && left == ADDR_WIDTH'(1));
  assign cnt_inc = (valid_count == depth) ? valid_count : valid_count + 1'b1;
  // once the buffer has wrapped, the write pointer points at the oldest sample
  assign rd_phys = ((valid_count == depth) ? wr_ptr : '0) + rd_addr;
  always_comb begin
    state_nx  = start ? ARMED : last ? DONE : (state == ARMED && trigger) ? POST : state;
    armed     = state == ARMED;
    capturing = state == POST;
    done      = state == DONE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= sample_data;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      post_lat    <= '0;
      left        <= '0;
      trig_pos    <= '0;
      valid_count <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= state == DONE && rd_en;
      if (state == DONE && rd_en) rd_data <= mem[rd_phys];
      if (start) begin
        post_lat    <= post_count;
        wr_ptr      <= '0;
        valid_count <= '0;
        trig_pos    <= '0;
      end else if (wr) begin
        wr_ptr      <= wr_ptr + 1'b1;
        valid_count <= cnt_inc;
        // ARMED keeps reloading the remaining-post count so it is ready on the trigger cycle
        left        <= (state == ARMED) ? post_lat : left - 1'b1;
        if (last) trig_pos <= ADDR_WIDTH'(cnt_inc - (ADDR_WIDTH+1)'(1) - {1'b0, post_lat});
      end
    end
  end
endmodule

// File: tb/tb_ila_capture_controller.sv
// tb_ila_capture_controller: self-checking bench for ila_capture_controller (DEPTH=16)
module tb_ila_capture_controller;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, trigger = 1'b0, rd_en = 1'b0;
  logic [31:0] sample_data = '0;
  logic [3:0]  post_count = '0, rd_addr = '0;
  logic        armed, capturing, done, rd_valid;
  logic [3:0]  trig_pos;
  logic [4:0]  valid_count;
  logic [31:0] rd_data;
  int checks = 0, fails = 0;
  logic [31:0] q[$];

  typedef struct {int post; int tk; int vc; int tp; int first;} vec_t;
  vec_t vecs[5];

  ila_capture_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .arm(arm), .trigger(trigger), .sample_data(sample_data),
    .post_count(post_count), .rd_en(rd_en), .rd_addr(rd_addr), .armed(armed),
    .capturing(capturing), .done(done), .trig_pos(trig_pos), .valid_count(valid_count),
    .rd_data(rd_data), .rd_valid(rd_valid));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Capture with trigger on cycle tk; model keeps every written sample and expects the last
  // min(n,16) of them in chronological order.
  task automatic do_capture(input int p, input int tk, input bit rnd);
    int total, ev, et;
    logic [31:0] d;
    q.delete();
    arm = 1'b1;
    post_count = 4'(p);
    step;
    arm = 1'b0;
    chk("arm_armed", 32'(armed), 32'd1);
    chk("arm_done", 32'(done), 32'd0);
    chk("arm_vc", 32'(valid_count), 32'd0);
    chk("arm_tp", 32'(trig_pos), 32'd0);
    total = tk + p + 1;
    for (int k = 0; k < total; k++) begin
      d = rnd ? $urandom : 32'(k);
      sample_data = d;
      trigger = (k == tk);
      q.push_back(d);
      step;
      trigger = 1'b0;
      chk("done_edge", 32'(done), 32'(k == total - 1));
      chk("capturing", 32'(capturing), 32'(k >= tk && k < total - 1));
      chk("armed", 32'(armed), 32'(k < tk));
    end
    ev = total > 16 ? 16 : total;
    et = ev - 1 - p;
    chk("valid_count", 32'(valid_count), 32'(ev));
    chk("trig_pos", 32'(trig_pos), 32'(et));
    rd_en = 1'b1;
    for (int i = 0; i < ev; i++) begin
      rd_addr = 4'(i);
      step;
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", rd_data, q[q.size() - ev + i]);
    end
    rd_en = 1'b0;
    step;
    chk("rd_valid_off", 32'(rd_valid), 32'd0);
    chk("done_hold", 32'(done), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4, 20, 16, 11, 9};
    vecs[1] = '{4, 3, 8, 3, 0};
    vecs[2] = '{15, 30, 16, 0, 30};
    vecs[3] = '{0, 5, 6, 5, 0};
    vecs[4] = '{2, 17, 16, 13, 4};

    step;
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_capturing", 32'(capturing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tp", 32'(trig_pos), 32'd0);
    chk("rst_vc", 32'(valid_count), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    rd_en = 1'b1;
    repeat (3) step;
    chk("idle_armed", 32'(armed), 32'd0);
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;

    // arm and trigger together in IDLE: arm wins
    arm = 1'b1;
    trigger = 1'b1;
    post_count = 4'd3;
    step;
    arm = 1'b0;
    trigger = 1'b0;
    chk("coin_armed", 32'(armed), 32'd1);
    chk("coin_capturing", 32'(capturing), 32'd0);
    chk("coin_done", 32'(done), 32'd0);
    rd_en = 1'b1;
    step;
    chk("armed_rd_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_armed", 32'(armed), 32'd0);
    reset = 1'b0;

    // trigger and arm during POST are ignored
    arm = 1'b1;
    post_count = 4'd4;
    step;
    for (int k = 0; k < 7; k++) begin
      sample_data = 32'(k);
      trigger = (k == 2 || k == 3);
      arm = (k == 0 || k == 3);
      step;
      trigger = 1'b0;
      arm = 1'b0;
      chk("col_done", 32'(done), 32'(k == 6));
      chk("col_capturing", 32'(capturing), 32'(k >= 2 && k < 6));
    end
    chk("col_vc", 32'(valid_count), 32'd7);
    chk("col_tp", 32'(trig_pos), 32'd2);

    // async reset between edges in the middle of POST
    arm = 1'b1;
    post_count = 4'd5;
    step;
    arm = 1'b0;
    trigger = 1'b1;
    step;
    trigger = 1'b0;
    step;
    chk("pre_rst_capturing", 32'(capturing), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_capturing", 32'(capturing), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_vc", 32'(valid_count), 32'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step;
      chk("post_rst_idle", 32'({armed, capturing, done}), 32'd0);
    end
    arm = 1'b1;
    post_count = 4'd1;
    step;
    arm = 1'b0;
    chk("clean_vc0", 32'(valid_count), 32'd0);
    step;
    chk("clean_vc1", 32'(valid_count), 32'd1);
    step;
    chk("clean_vc2", 32'(valid_count), 32'd2);
    reset = 1'b1;
    #2 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_capture(vecs[i].post, vecs[i].tk, 1'b0);
      chk("tbl_vc", 32'(valid_count), 32'(vecs[i].vc));
      chk("tbl_tp", 32'(trig_pos), 32'(vecs[i].tp));
      rd_en = 1'b1;
      rd_addr = 4'd0;
      step;
      rd_en = 1'b0;
      chk("tbl_first", rd_data, 32'(vecs[i].first));
    end

    // reset in DONE while a read is returning
    rd_en = 1'b1;
    rd_addr = 4'd1;
    step;
    chk("done_rd_valid", 32'(rd_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_done_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done_rd_data", rd_data, 32'd0);
    chk("rst_done_done", 32'(done), 32'd0);
    rd_en = 1'b0;
    #2 reset = 1'b0;

    for (int t = 0; t < 8; t++)
      do_capture(int'($urandom_range(0, 15)), int'($urandom_range(0, 40)), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ila_capture_controller.md
ILA_CAPTURE_CONTROLLER -- requirements
Module: ila_capture_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the sample width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving buffer depth DEPTH = 2**ADDR_WIDTH samples.
REQ-003 The block SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port arm  input  1  one-cycle pulse that starts a capture.
REQ-006 The block SHALL have port trigger  input  1  one-cycle trigger pulse from the trigger generator.
REQ-007 The block SHALL have port sample_data  input  DATA_WIDTH  probe data to capture.
REQ-008 The block SHALL have port post_count  input  ADDR_WIDTH  number of samples to store after the trigger sample.
REQ-009 The block SHALL have port rd_en  input  1  read request.
REQ-010 The block SHALL have port rd_addr  input  ADDR_WIDTH  chronological read index; 0 is the oldest sample.
REQ-011 The block SHALL have port armed  output  1  high in ARMED.
REQ-012 The block SHALL have port capturing  output  1  high in POST.
REQ-013 The block SHALL have port done  output  1  high in DONE.
REQ-014 The block SHALL have port trig_pos  output  ADDR_WIDTH  chronological index of the trigger sample.
REQ-015 The block SHALL have port valid_count  output  ADDR_WIDTH+1  number of valid samples held.
REQ-016 The block SHALL have port rd_data  output  DATA_WIDTH  read data.
REQ-017 The block SHALL have port rd_valid  output  1  read data valid strobe.

Function
REQ-018 The state machine SHALL have the states IDLE, ARMED, POST and DONE.
REQ-019 arm in IDLE or DONE SHALL move the block to ARMED, latch post_count clamped to DEPTH-1, and zero the write pointer, the sample counter and trig_pos; arm in ARMED or POST SHALL be ignored.
REQ-020 In ARMED and POST, sample_data SHALL be written to the buffer at the write pointer on every cycle, and the pointer SHALL then increment modulo DEPTH.
REQ-021 The sample counter SHALL count writes and saturate at DEPTH.
REQ-022 trigger in ARMED SHALL make that cycle's sample the trigger sample; with latched post 0 the block SHALL go to DONE, otherwise it SHALL go to POST.
REQ-023 POST SHALL write exactly the latched post number of further samples and then go to DONE.
REQ-024 done SHALL rise on the clock edge that writes the final post sample.
REQ-025 trigger in IDLE, POST or DONE SHALL be ignored.
REQ-026 When arm and trigger coincide in IDLE or DONE, arm SHALL take effect and trigger SHALL be ignored.
REQ-027 On entry to DONE, valid_count SHALL equal the saturated sample counter, and trig_pos SHALL equal valid_count - 1 - latched post.
REQ-028 In DONE, no buffer writes SHALL occur, and the contents SHALL hold until the next arm.
REQ-029 For reads, the physical address SHALL be (oldest + rd_addr) mod DEPTH, where oldest is the write pointer if the counter saturated and 0 otherwise.
REQ-030 rd_en in DONE SHALL return rd_data with rd_valid high exactly one cycle later.
REQ-031 rd_en outside DONE SHALL be ignored, with rd_valid staying 0.
REQ-032 A read with rd_addr >= valid_count SHALL return unspecified data with rd_valid still asserted.
REQ-033 armed, capturing and done SHALL be mutually exclusive.
REQ-034 A trigger that arrives before DEPTH-1-post samples are stored SHALL be accepted, and valid_count then reports the short capture.

Reset
REQ-035 Asserting reset SHALL, without waiting for a clock edge, force the state to IDLE and clear armed, capturing, done, trig_pos, valid_count, rd_data, rd_valid, the pointers and the counters.
REQ-036 Buffer memory contents SHALL NOT be reset.
REQ-037 Reset during ARMED or POST SHALL abandon the capture, and no done SHALL follow.
REQ-038 After reset deasserts, the block SHALL remain in IDLE until arm.

Verification (ADDR_WIDTH=4, DEPTH=16; sample_data = k on the k-th capture cycle, k from 0)
REQ-039 Normal wrap: post_count=4, trigger at k=20 -> done after the k=24 write; valid_count=16; trig_pos=11; rd_addr 0..15 returns 9..24.
REQ-040 Early trigger: post_count=4, trigger at k=3 -> valid_count=8; trig_pos=3; rd_addr 0..7 returns 0..7.
REQ-041 Clamp and zero-post cases: post_count=15, trigger at k=30 -> trig_pos=0 and data 30..45. post_count=0, trigger at k=5 -> done the next cycle; trig_pos=5; valid_count=6.
REQ-042 Collisions: arm and trigger together in IDLE -> armed=1 with no capture ended. trigger during POST -> no effect. arm during POST -> no effect. rd_en in ARMED -> rd_valid stays 0.
REQ-043 Async reset mid-POST, asserted between clock edges -> capturing, done and rd_valid go 0 immediately; the block stays IDLE after release; a new arm starts a clean capture with valid_count counting from 0.
REQ-044 Re-arm from DONE -> done=0 and armed=1 on the next edge; a second capture (post_count=2, trigger at k=17) gives trig_pos=13 and readout 4..19.
